// File: rtl/crossing_pkg.sv
// Shared types and default parameters for the pedestrian/vehicle crossing
// request block.
package crossing_pkg;

  // Request-FSM states
  typedef enum logic [1:0] {
    WAIT_GREEN = 2'd0,
    MIN_HOLD   = 2'd1,
    SERVE      = 2'd2,
    HANDOFF    = 2'd3
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_MIN_GREEN       = 8;
  localparam int DEF_MAX_GREEN       = 32;

endpackage

// File: rtl/crossing_request_debounce.sv
// Two-flop synchroniser followed by a stability counter. The debounced level
// follows the synchronised input only after it has differed from the current
// level for DEBOUNCE_CYCLES consecutive cycles.
module debounce
  import crossing_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  // Bring the asynchronous input into the clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // Accept a new level only after it has been stable long enough
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_q2 != level) begin
      if (cnt == LAST) begin
        level <= sync_q2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/crossing_request.sv
// Crossing request generator: debounces the pedestrian button and the
// vehicle sensor, latches a request, and asks the light controller for a
// phase change once green has been held for MIN_GREEN cycles.
// Optional feature macro CROSSING_REQUEST_MAX_GREEN_EN: force a handoff
// (with a one-cycle timeout pulse) when green has been held MAX_GREEN cycles
// without any request.
// Handshake: next is a level request held high in HANDOFF; the controller
// acknowledges by dropping green, which clears the latch and ends the request.
module crossing_request
  import crossing_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int MIN_GREEN       = DEF_MIN_GREEN,
  parameter int MAX_GREEN       = DEF_MAX_GREEN
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   green,
  input  logic   ped_btn,
  input  logic   car_wait,
  output logic   next,
  output logic   req_pending,
  output logic   timeout,
  output state_t fsm_state
);

  // Reject illegal parameter sets at elaboration
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("crossing_request: DEBOUNCE_CYCLES must be >= 1");
  end
  if (MIN_GREEN < 1) begin : g_bad_min_green
    $error("crossing_request: MIN_GREEN must be >= 1");
  end
  if (MAX_GREEN <= MIN_GREEN) begin : g_bad_max_green
    $error("crossing_request: MAX_GREEN must exceed MIN_GREEN");
  end

  localparam int HW = $clog2(MAX_GREEN);
  localparam logic [HW-1:0] MIN_LAST = HW'(MIN_GREEN - 1);
`ifdef CROSSING_REQUEST_MAX_GREEN_EN
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_GREEN - 1);
`else
  localparam logic [HW-1:0] HOLD_LAST = MIN_LAST;
`endif

  logic          ped_level;
  logic          car_level;
  logic          ped_prev;
  logic          set_req;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_inc;

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ped_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (ped_btn),
    .level (ped_level)
  );

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_car_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (car_wait),
    .level (car_level)
  );

  // A button press counts once (on its edge); a waiting car keeps asking
  assign set_req  = (ped_level & ~ped_prev) | car_level;
  // Hold counter saturates at the last value the FSM ever compares against
  assign hold_inc = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 1'b1;

  // Remember the previous debounced button level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ped_prev <= 1'b0;
    else        ped_prev <= ped_level;
  end

  // Request latch: frozen during HANDOFF, cleared when the handoff completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_pending <= 1'b0;
    end else if (fsm_state == HANDOFF) begin
      if (!green) req_pending <= 1'b0;
    end else if (set_req) begin
      req_pending <= 1'b1;
    end
  end

  // Phase FSM with hold counter and registered next/timeout outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_state <= WAIT_GREEN;
      hold_cnt  <= '0;
      next      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (fsm_state)
        WAIT_GREEN: begin
          if (green) begin
            fsm_state <= MIN_HOLD;
            hold_cnt  <= '0;
          end
        end
        MIN_HOLD: begin
          if (!green) begin
            fsm_state <= WAIT_GREEN;
          end else begin
            hold_cnt <= hold_inc;
            if (hold_cnt == MIN_LAST) fsm_state <= SERVE;
          end
        end
        SERVE: begin
          if (!green) begin
            fsm_state <= WAIT_GREEN;
          end else if (req_pending) begin
            fsm_state <= HANDOFF;
            next      <= 1'b1;
          end else begin
            hold_cnt <= hold_inc;
`ifdef CROSSING_REQUEST_MAX_GREEN_EN
            if (hold_cnt == HOLD_LAST) begin
              fsm_state <= HANDOFF;
              next      <= 1'b1;
              timeout   <= 1'b1;
            end
`endif
          end
        end
        HANDOFF: begin
          if (!green) begin
            fsm_state <= WAIT_GREEN;
            next      <= 1'b0;
          end
        end
        default: begin
          fsm_state <= WAIT_GREEN;
          next      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crossing_request.sv
// Directed bench for crossing_request (default parameters). Inputs are
// driven and outputs sampled 1 ns after the rising clock edge.
module tb_crossing_request;
  import crossing_pkg::*;

  logic   clk;
  logic   rst_n;
  logic   green;
  logic   ped_btn;
  logic   car_wait;
  logic   next;
  logic   req_pending;
  logic   timeout;
  state_t fsm_state;

  int n_tests = 0;
  int n_fail  = 0;

  crossing_request dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .green       (green),
    .ped_btn     (ped_btn),
    .car_wait    (car_wait),
    .next        (next),
    .req_pending (req_pending),
    .timeout     (timeout),
    .fsm_state   (fsm_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    green    = 1'b0;
    ped_btn  = 1'b0;
    car_wait = 1'b0;
    #2;
    // Reset state before any clock edge
    check("rst_next", 32'(next), 32'd0);
    check("rst_req", 32'(req_pending), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(WAIT_GREEN));
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Green with no inputs: no request, FSM walks to SERVE
    green = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      check("idle_next", 32'(next), 32'd0);
      check("idle_req", 32'(req_pending), 32'd0);
      if (i == 1) check("idle_minhold_a", 32'(fsm_state), 32'(MIN_HOLD));
      if (i == 8) check("idle_minhold_b", 32'(fsm_state), 32'(MIN_HOLD));
      if (i == 9) check("idle_serve", 32'(fsm_state), 32'(SERVE));
    end

    // Restart the green phase, then a 2-cycle glitch on the button
    green = 1'b0;
    tick(1);
    check("drop_state", 32'(fsm_state), 32'(WAIT_GREEN));
    green = 1'b1;
    tick(9);
    ped_btn = 1'b1;
    tick(2);
    ped_btn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("glitch_req", 32'(req_pending), 32'd0);
    end

    // Held press: latch exactly 7 cycles after the edge, next one later
    ped_btn = 1'b1;
    tick(6);
    check("press_req_c6", 32'(req_pending), 32'd0);
    tick(1);
    check("press_req_c7", 32'(req_pending), 32'd1);
    check("press_next_c7", 32'(next), 32'd0);
    tick(1);
    check("press_next_c8", 32'(next), 32'd1);
    check("press_state_c8", 32'(fsm_state), 32'(HANDOFF));
    tick(2);
    ped_btn = 1'b0;
    green   = 1'b0;
    tick(1);
    check("handoff_end_next", 32'(next), 32'd0);
    check("handoff_end_req", 32'(req_pending), 32'd0);
    check("handoff_end_state", 32'(fsm_state), 32'(WAIT_GREEN));
    tick(8);

    // Request latched while red, then green: next first on the 10th tick
    ped_btn = 1'b1;
    tick(7);
    check("pre_req", 32'(req_pending), 32'd1);
    check("pre_state", 32'(fsm_state), 32'(WAIT_GREEN));
    ped_btn = 1'b0;
    tick(8);
    green = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick(1);
      check("pre_next_low", 32'(next), 32'd0);
    end
    tick(1);
    check("pre_next_high", 32'(next), 32'd1);
    green = 1'b0;
    tick(1);
    check("pre_drop_next", 32'(next), 32'd0);
    check("pre_drop_req", 32'(req_pending), 32'd0);

    // Green falls in SERVE with a car waiting: latch kept
    green = 1'b1;
    tick(9);
    check("car_serve", 32'(fsm_state), 32'(SERVE));
    car_wait = 1'b1;
    tick(6);
    check("car_req_c6", 32'(req_pending), 32'd0);
    tick(1);
    check("car_req_c7", 32'(req_pending), 32'd1);
    check("car_state_c7", 32'(fsm_state), 32'(SERVE));
    green = 1'b0;
    tick(1);
    check("car_drop_state", 32'(fsm_state), 32'(WAIT_GREEN));
    check("car_drop_req", 32'(req_pending), 32'd1);
    check("car_drop_next", 32'(next), 32'd0);

    // Back to green, reach HANDOFF, then reset mid-HANDOFF
    green = 1'b1;
    tick(9);
    check("car_next_c9", 32'(next), 32'd0);
    tick(1);
    check("car_next_c10", 32'(next), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_next", 32'(next), 32'd0);
    check("mid_rst_req", 32'(req_pending), 32'd0);
    check("mid_rst_state", 32'(fsm_state), 32'(WAIT_GREEN));
    car_wait = 1'b0;
    green    = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Long green with no requests
    green = 1'b1;
`ifdef CROSSING_REQUEST_MAX_GREEN_EN
    tick(32);
    check("max_next_c32", 32'(next), 32'd0);
    check("max_timeout_c32", 32'(timeout), 32'd0);
    tick(1);
    check("max_next_c33", 32'(next), 32'd1);
    check("max_timeout_c33", 32'(timeout), 32'd1);
    tick(1);
    check("max_next_c34", 32'(next), 32'd1);
    check("max_timeout_c34", 32'(timeout), 32'd0);
`else
    for (int i = 0; i < 100; i++) begin
      tick(1);
      check("long_next", 32'(next), 32'd0);
      check("long_timeout", 32'(timeout), 32'd0);
    end
    check("long_state", 32'(fsm_state), 32'(SERVE));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
